cbc_encipher_stream: RTL and testbench

CBC_ENCIPHER_STREAM -- requirements
Module: cbc_encipher_stream

---
 rtl/cbc_encipher_stream.sv | 181 ++++++++++++++++++
 tb/tb_cbc_encipher_stream.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbc_encipher_stream.sv
`default_nettype none
// ============================================================================
//  Module   : cbc_encipher_stream (with helper present_cipher)
//  Purpose  : Streams one frame of NBLK 16-bit plaintext blocks through a
//             16-bit PRESENT-style block cipher in CBC mode. The output is
//             registered and has valid/ready flow control.
//  Ports    : clk, rst_n (synchronous, active-low)
//             start, init_vec[15:0], key[19:0]  - frame start; IV and key
//                                                 are latched on acceptance
//             pt_valid/pt_ready, pt_data[15:0] - plaintext input stream
//             ct_valid/ct_ready, ct_data[15:0], ct_last - ciphertext stream
//             busy - not idle; done - one-cycle pulse after the last block
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  present_cipher: purely combinational, unrolled 6-round SPN.
//  Each round XORs in the round key, applies the PRESENT 4-bit S-box to every
//  nibble, and then moves bit i to bit (4*i mod 15), with bit 15 fixed.
//  The round key is k[19:4] ^ k[3:0], so every key bit contributes.
//  Key schedule: rotate left by 7, S-box the top nibble, then XOR the round
//  number into k[8:4]. A final key add follows the last round.
// ----------------------------------------------------------------------------
module present_cipher (
    input  logic [15:0] blk_in,
    input  logic [19:0] key,
    output logic [15:0] blk_out
);
    localparam int c_ROUNDS = 6;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] sub_perm(input logic [15:0] s);
        logic [15:0] t;
        logic [15:0] o;
        for (int n = 0; n < 4; n++) begin
            t[n*4 +: 4] = sbox(s[n*4 +: 4]);
        end
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[(i == 15) ? 15 : ((i * 4) % 15)] = t[i];
        end
        return o;
    endfunction

    function automatic logic [15:0] round_key(input logic [19:0] k);
        return k[19:4] ^ {12'h000, k[3:0]};
    endfunction

    function automatic logic [19:0] key_next(input logic [19:0] k, input logic [4:0] rc);
        logic [19:0] t;
        t         = {k[12:0], k[19:13]};
        t[19:16]  = sbox(t[19:16]);
        t[8:4]    = t[8:4] ^ rc;
        return t;
    endfunction

    logic [15:0] w_state [0:c_ROUNDS];
    logic [19:0] w_rkey  [0:c_ROUNDS];

    assign w_state[0] = blk_in;
    assign w_rkey[0]  = key;

    for (genvar r = 0; r < c_ROUNDS; r++) begin : g_round
        assign w_state[r+1] = sub_perm(w_state[r] ^ round_key(w_rkey[r]));
        assign w_rkey[r+1]  = key_next(w_rkey[r], 5'(r + 1));
    end

    assign blk_out = w_state[c_ROUNDS] ^ round_key(w_rkey[c_ROUNDS]);
endmodule

module cbc_encipher_stream #(
    parameter int NBLK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] init_vec,
    input  logic [19:0] key,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic [15:0] pt_data,
    output logic        ct_valid,
    input  logic        ct_ready,
    output logic [15:0] ct_data,
    output logic        ct_last,
    output logic        busy,
    output logic        done
);
    localparam int c_CW = $clog2(NBLK);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_chain;
    logic [19:0]       r_key;
    logic [c_CW-1:0]   r_blk_cnt;
    logic [15:0]       w_cipher_out;
    logic              w_pt_fire;
    logic              w_ct_fire;
    logic              w_last_blk;

    // The output register holds only one block, so input is accepted only
    // when that register is empty or is being emptied in the same cycle.
    // rst_n gates the ready signal so no handshake can appear during reset.
    assign pt_ready   = rst_n && (r_state == S_RUN) && (!ct_valid || ct_ready);
    assign w_pt_fire  = pt_valid && pt_ready;
    assign w_ct_fire  = ct_valid && ct_ready;
    assign w_last_blk = (r_blk_cnt == c_CW'(NBLK - 1));
    assign busy       = (r_state != S_IDLE);

    present_cipher u_cipher (
        .blk_in  (r_chain ^ pt_data),
        .key     (r_key),
        .blk_out (w_cipher_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_pt_fire && w_last_blk) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_ct_fire && ct_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_chain   <= '0;
            r_key     <= '0;
            r_blk_cnt <= '0;
            ct_valid  <= 1'b0;
            ct_data   <= '0;
            ct_last   <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            done    <= (r_state == S_DRAIN) && w_ct_fire && ct_last;

            if ((r_state == S_IDLE) && start) begin
                r_chain   <= init_vec;
                r_key     <= key;
                r_blk_cnt <= '0;
            end

            // A new block takes priority: it refills the output register in
            // the same cycle that the previous block drains.
            if (w_pt_fire) begin
                ct_data  <= w_cipher_out;
                r_chain  <= w_cipher_out;
                ct_valid <= 1'b1;
                ct_last  <= w_last_blk;
                // Holding the counter on the final block keeps it from
                // wrapping when NBLK is a power of two.
                if (!w_last_blk) begin
                    r_blk_cnt <= r_blk_cnt + 1'b1;
                end
            end else if (w_ct_fire) begin
                ct_valid <= 1'b0;
                ct_last  <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cbc_encipher_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbc_encipher_stream
//  Purpose  : Self-checking bench for cbc_encipher_stream. It covers directed
//             frames, backpressure, start while busy, reset in mid-frame,
//             back-to-back frames and randomized frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cbc_encipher_stream;
    localparam int NBLK = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] init_vec = '0;
    logic [19:0] key = '0;
    logic        pt_valid = 1'b0;
    logic        pt_ready;
    logic [15:0] pt_data = '0;
    logic        ct_valid;
    logic        ct_ready = 1'b0;
    logic [15:0] ct_data;
    logic        ct_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    cbc_encipher_stream #(.NBLK(NBLK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_vec(init_vec), .key(key),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .ct_last(ct_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- cipher reference (from its definition) ----------------
    function automatic logic [3:0] m_sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;   // nibble n = S(n)
        return tbl[x*4 +: 4];
    endfunction

    function automatic logic [3:0] m_sbox_inv(input logic [3:0] y);
        logic [3:0] r;
        r = '0;
        for (int v = 0; v < 16; v++) if (m_sbox(4'(v)) == y) r = 4'(v);
        return r;
    endfunction

    function automatic int m_dst(input int i);
        return (i == 15) ? 15 : (4 * i) % 15;
    endfunction

    function automatic logic [15:0] m_perm(input logic [15:0] s);
        logic [15:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[m_dst(i)] = s[i];
        return o;
    endfunction

    function automatic logic [15:0] m_perm_inv(input logic [15:0] s);
        logic [15:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[i] = s[m_dst(i)];
        return o;
    endfunction

    function automatic logic [15:0] m_sub(input logic [15:0] s, input bit inv);
        logic [15:0] o;
        for (int n = 0; n < 4; n++)
            o[n*4 +: 4] = inv ? m_sbox_inv(s[n*4 +: 4]) : m_sbox(s[n*4 +: 4]);
        return o;
    endfunction

    function automatic logic [15:0] m_rk(input logic [19:0] k);
        return k[19:4] ^ {12'h000, k[3:0]};
    endfunction

    function automatic logic [19:0] m_key_next(input logic [19:0] k, input int rc);
        logic [19:0] t;
        t = {k[12:0], k[19:13]};
        t[19:16] = m_sbox(t[19:16]);
        t[8:4] = t[8:4] ^ 5'(rc);
        return t;
    endfunction

    function automatic logic [15:0] m_enc(input logic [19:0] k, input logic [15:0] p);
        logic [15:0] s;
        s = p;
        for (int r = 1; r <= 6; r++) begin
            s = m_perm(m_sub(s ^ m_rk(k), 1'b0));
            k = m_key_next(k, r);
        end
        return s ^ m_rk(k);
    endfunction

    function automatic logic [15:0] m_dec(input logic [19:0] k, input logic [15:0] c);
        logic [19:0] ks [7];
        logic [15:0] s;
        ks[0] = k;
        for (int r = 1; r <= 6; r++) ks[r] = m_key_next(ks[r-1], r);
        s = c ^ m_rk(ks[6]);
        for (int r = 6; r >= 1; r--) s = m_sub(m_perm_inv(s), 1'b1) ^ m_rk(ks[r-1]);
        return s;
    endfunction

    // ---------------- stream model + per-cycle compare ----------------
    typedef struct packed { logic [15:0] d; logic last; } exp_t;
    exp_t        exp_q[$];
    logic [15:0] obs[$];
    bit          armed = 0, m_idle = 1, exp_done = 0, after_rst = 0;
    int          m_acc = 0;
    logic [15:0] m_chain;
    logic [19:0] m_key;

    always @(negedge clk) begin
        bit was_idle, pf, cf;
        if (armed) begin
            chk("ct_valid", ct_valid, exp_q.size() != 0);
            if (ct_valid && exp_q.size() != 0) begin
                chk("ct_data", ct_data, exp_q[0].d);
                chk("ct_last", ct_last, exp_q[0].last);
            end
            chk("done", done, exp_done);
            chk("busy", busy, !m_idle);
            chk("pt_ready", pt_ready,
                rst_n && !m_idle && (m_acc < NBLK) && (exp_q.size() == 0 || ct_ready));
            if (after_rst) begin
                chk("rst_ct_data", ct_data, 0);
                chk("rst_ct_last", ct_last, 0);
            end
        end
        if (!rst_n) begin
            armed = 1; m_idle = 1; exp_q.delete(); exp_done = 0; after_rst = 1; m_acc = 0;
        end else begin
            after_rst = 0;
            exp_done = 0;
            was_idle = m_idle;
            pf = pt_valid && pt_ready;
            cf = ct_valid && ct_ready;
            if (cf && exp_q.size() != 0) begin
                obs.push_back(ct_data);
                if (exp_q[0].last) begin exp_done = 1; m_idle = 1; end
                void'(exp_q.pop_front());
            end
            if (pf) begin
                m_chain = m_enc(m_key, m_chain ^ pt_data);
                exp_q.push_back('{d: m_chain, last: (m_acc == NBLK - 1)});
                m_acc++;
            end
            if (was_idle && start) begin
                m_idle = 0; m_chain = init_vec; m_key = key; m_acc = 0;
            end
        end
    end

    // ---------------- driver ----------------
    logic [15:0] pt_buf [NBLK];
    logic [15:0] ref_ct [NBLK];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [19:0] k, input logic [15:0] iv);
        obs.delete();
        start = 1; key = k; init_vec = iv;
        tick();
        start = 0; key = 20'($urandom); init_vec = 16'($urandom);
    endtask

    // mode 1 = random valid/ready; bp_blk: hold ct_ready low 5 cycles after
    // that block; sir_blk: pulse start while that block is offered;
    // rst_blk: assert reset right after that block is accepted.
    task automatic send_frame(input int mode, input int bp_blk, input int sir_blk, input int rst_blk);
        int i = 0, bp = 0, budget = 0;
        bit fire;
        while (i < NBLK && budget < 2000) begin
            pt_data  = pt_buf[i];
            pt_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bp > 0) begin ct_ready = 0; bp--; end
            else ct_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sir_blk == i) begin start = 1; init_vec = 16'hFFFF; key = 20'($urandom); end
            @(negedge clk);
            fire = pt_valid && pt_ready;
            tick();
            start = 0;
            budget++;
            if (fire) begin
                if (i == bp_blk) bp = 5;
                if (i == rst_blk) begin
                    pt_valid = 0; rst_n = 0;
                    tick();
                    rst_n = 1;
                    return;
                end
                i++;
            end
        end
        pt_valid = 0;
        while (!done && budget < 2000) begin
            if (bp > 0) begin ct_ready = 0; bp--; end
            else ct_ready = (mode == 1) ? ($urandom_range(0, 1) != 0) : 1'b1;
            tick();
            budget++;
        end
        chk("frame_completes", budget < 2000, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prev, p;
        logic [19:0] k2;
        logic [15:0] iv2;

        // Pin the cipher model against hand-derived values.
        chk("model_sbox0", m_sbox(4'h0), 4'hC);
        chk("model_sboxF", m_sbox(4'hF), 4'h2);
        chk("model_perm2", m_perm(16'h0002), 16'h0010);
        chk("model_perm10", m_perm(16'h0010), 16'h0002);
        chk("model_perm8000", m_perm(16'h8000), 16'h8000);
        chk("model_keynext", m_key_next(20'h00000, 1), 20'hC0010);
        chk("model_rk", m_rk(20'hC0013), 16'hC002);

        repeat (3) tick();
        rst_n = 1;
        tick();

        // Single frame, reference run.
        for (int i = 0; i < NBLK; i++) pt_buf[i] = 16'(i);
        do_start(20'hABCDE, 16'h1234);
        send_frame(0, -1, -1, -1);
        chk("f1_count", obs.size(), NBLK);
        for (int i = 0; i < NBLK; i++) ref_ct[i] = (i < obs.size()) ? obs[i] : 16'hxxxx;
        // Round trip through the inverse cipher in CBC.
        prev = 16'h1234;
        for (int i = 0; i < NBLK; i++) begin
            p = m_dec(20'hABCDE, ref_ct[i]) ^ prev;
            chk("roundtrip", p, i);
            prev = ref_ct[i];
        end

        // Backpressure after block 2.
        tick();
        do_start(20'hABCDE, 16'h1234);
        send_frame(0, 2, -1, -1);
        chk("bp_count", obs.size(), NBLK);
        for (int i = 0; i < NBLK && i < obs.size(); i++) chk("bp_seq", obs[i], ref_ct[i]);

        // Start pulsed while running.
        tick();
        do_start(20'hABCDE, 16'h1234);
        send_frame(0, -1, 3, -1);
        chk("sir_count", obs.size(), NBLK);
        for (int i = 0; i < NBLK && i < obs.size(); i++) chk("sir_seq", obs[i], ref_ct[i]);

        // Reset after block 4, then a fresh frame with IV 0.
        tick();
        do_start(20'hABCDE, 16'h1234);
        send_frame(0, -1, -1, 4);
        chk("rst_ct_valid", ct_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pt_ready", pt_ready, 0);
        tick();
        do_start(20'hABCDE, 16'h0000);
        send_frame(0, -1, -1, -1);
        chk("iv0_ct0", (obs.size() > 0) ? obs[0] : 16'hxxxx, m_enc(20'hABCDE, 16'h0000));

        // Back-to-back: start issued in the done cycle.
        k2 = 20'h13579; iv2 = 16'hBEEF;
        for (int i = 0; i < NBLK; i++) pt_buf[i] = 16'($urandom);
        do_start(k2, iv2);
        send_frame(0, -1, -1, -1);
        chk("b2b_ct0", (obs.size() > 0) ? obs[0] : 16'hxxxx, m_enc(k2, pt_buf[0] ^ iv2));

        // Randomized frames with random flow control.
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) tick();
            for (int i = 0; i < NBLK; i++) pt_buf[i] = 16'($urandom);
            do_start(20'($urandom), 16'($urandom));
            send_frame(1, -1, (f == 2) ? 1 : -1, -1);
            chk("rand_count", obs.size(), NBLK);
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
